line_video_out: RTL and testbench



---
 rtl/line_video_out_if.sv | 34 +++
 rtl/line_video_out.sv | 157 +++++++++++++++
 tb/tb_line_video_out.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_video_out_if.sv
// Read-side bundle between the line sequencer, the ping-pong line buffer and
// the downstream video/host interface.
interface line_video_out_if #(
   parameter int DATA_W = 14
);
   logic              i_line_ready;
   logic              i_slow_mode;
   logic [DATA_W-1:0] i_buf_data;
   logic              o_bufer_change;
   logic              o_bufer_out_en;
   logic              o_low_speed_out;
   logic [9:0]        o_pix_out;
   logic [DATA_W-1:0] o_pix_data;
   logic              o_pix_valid;
   logic              o_line_valid;
   logic              o_frame_start;
   logic              o_frame_done;
   logic [9:0]        o_line_num;
   logic              o_overrun;

   modport master (
      input  i_line_ready, i_slow_mode, i_buf_data,
      output o_bufer_change, o_bufer_out_en, o_low_speed_out, o_pix_out,
             o_pix_data, o_pix_valid, o_line_valid, o_frame_start,
             o_frame_done, o_line_num, o_overrun
   );

   modport slave (
      output i_line_ready, i_slow_mode, i_buf_data,
      input  o_bufer_change, o_bufer_out_en, o_low_speed_out, o_pix_out,
             o_pix_data, o_pix_valid, o_line_valid, o_frame_start,
             o_frame_done, o_line_num, o_overrun
   );
endinterface

// File: rtl/line_video_out.sv
// Output-domain read sequencer for the ping-pong line buffer: swaps halves on
// each completed line, drives fast or low-speed readout, emits a pixel stream.
module line_video_out #(
   parameter int DATA_W   = 14,
   parameter int PIX_ROW  = 640,
   parameter int ROWS     = 480,
   parameter int HBLANK   = 32,
   parameter int SLOW_DIV = 4
) (
   input logic               i_clk,
   input logic               i_rst_n,
   line_video_out_if.master  bus
);
   localparam int HOLD_W  = ($clog2(SLOW_DIV) > 3) ? $clog2(SLOW_DIV) : 3;
   localparam int BLANK_W = ($clog2(HBLANK) > 1) ? $clog2(HBLANK) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWAP  = 2'd1;
   localparam logic [1:0] S_LINE  = 2'd2;
   localparam logic [1:0] S_BLANK = 2'd3;

   logic [1:0]         r_state;
   logic               r_mode;
   logic               r_bufer_change;
   logic               r_en;
   logic               r_low_speed;
   logic [9:0]         r_pix_cnt;
   logic [HOLD_W-1:0]  r_hold;
   logic [BLANK_W-1:0] r_blank;
   logic [9:0]         r_line_num;
   logic               r_frame_done;
   logic               r_overrun;
   logic               r_en_fast_d1;
   logic               r_pix_valid;
   logic [DATA_W-1:0]  r_pix_data;
   logic               r_line_valid;
   logic               r_frame_start;
   logic [9:0]         r_vcnt;

   logic w_accept;
   logic w_pv_next;

   // Fast data arrives one cycle after the enable; slow data is ready at hold index 2.
   assign w_accept  = bus.i_line_ready && (r_state == S_IDLE);
   assign w_pv_next = r_en_fast_d1 ||
                      ((r_state == S_LINE) && r_low_speed && (r_hold == HOLD_W'(2)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_mode         <= 1'b0;
         r_bufer_change <= 1'b0;
         r_en           <= 1'b0;
         r_low_speed    <= 1'b0;
         r_pix_cnt      <= '0;
         r_hold         <= '0;
         r_blank        <= '0;
         r_line_num     <= '0;
         r_frame_done   <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (bus.i_line_ready && (r_state != S_IDLE))
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.i_line_ready) begin
                  r_bufer_change <= ~r_bufer_change;
                  r_mode         <= bus.i_slow_mode;
                  r_state        <= S_SWAP;
               end
            end
            S_SWAP: begin
               r_state     <= S_LINE;
               r_en        <= 1'b1;
               r_low_speed <= r_mode;
               r_pix_cnt   <= '0;
               r_hold      <= '0;
            end
            S_LINE: begin
               if (!r_low_speed) begin
                  if (r_pix_cnt == 10'(PIX_ROW - 1)) begin
                     r_state   <= S_BLANK;
                     r_en      <= 1'b0;
                     r_pix_cnt <= '0;
                     r_blank   <= '0;
                  end else begin
                     r_pix_cnt <= r_pix_cnt + 10'd1;
                  end
               end else if (r_hold == HOLD_W'(SLOW_DIV - 1)) begin
                  r_hold <= '0;
                  if (r_pix_cnt == 10'(PIX_ROW - 1)) begin
                     r_state     <= S_BLANK;
                     r_en        <= 1'b0;
                     r_low_speed <= 1'b0;
                     r_pix_cnt   <= '0;
                     r_blank     <= '0;
                  end else begin
                     r_pix_cnt <= r_pix_cnt + 10'd1;
                  end
               end else begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
            S_BLANK: begin
               if (r_blank == BLANK_W'(HBLANK - 1)) begin
                  r_state <= S_IDLE;
                  if (r_line_num == 10'(ROWS - 1)) begin
                     r_line_num   <= '0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_line_num <= r_line_num + 10'd1;
                  end
               end else begin
                  r_blank <= r_blank + BLANK_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pixel stream stage; r_vcnt counts emitted pixels so LINE_VALID can bridge slow gaps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_en_fast_d1  <= 1'b0;
         r_pix_valid   <= 1'b0;
         r_pix_data    <= '0;
         r_line_valid  <= 1'b0;
         r_frame_start <= 1'b0;
         r_vcnt        <= '0;
      end else begin
         r_en_fast_d1  <= r_en && !r_low_speed;
         r_pix_valid   <= w_pv_next;
         if (w_pv_next)
            r_pix_data <= bus.i_buf_data;
         r_frame_start <= w_pv_next && (r_vcnt == 10'd0) && (r_line_num == 10'd0);
         r_line_valid  <= w_pv_next || (r_line_valid && (r_vcnt != 10'(PIX_ROW)));
         if (w_accept)
            r_vcnt <= '0;
         else if (w_pv_next)
            r_vcnt <= r_vcnt + 10'd1;
      end
   end

   assign bus.o_bufer_change  = r_bufer_change;
   assign bus.o_bufer_out_en  = r_en;
   assign bus.o_low_speed_out = r_low_speed;
   assign bus.o_pix_out       = r_low_speed ? r_pix_cnt : 10'd0;
   assign bus.o_pix_data      = r_pix_data;
   assign bus.o_pix_valid     = r_pix_valid;
   assign bus.o_line_valid    = r_line_valid;
   assign bus.o_frame_start   = r_frame_start;
   assign bus.o_frame_done    = r_frame_done;
   assign bus.o_line_num      = r_line_num;
   assign bus.o_overrun       = r_overrun;
endmodule

// File: tb/tb_line_video_out.sv
// Bench for line_video_out: models the ping-pong buffer read port and checks the
// pixel stream against a scoreboard of expected buffer contents.
module tb_line_video_out;
   localparam int DATA_W   = 14;
   localparam int PIX_ROW  = 8;
   localparam int ROWS     = 3;
   localparam int HBLANK   = 2;
   localparam int SLOW_DIV = 4;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [9:0]        lineNum;
      logic              first;
   } expPix_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   line_video_out_if #(.DATA_W(DATA_W)) bus();

   line_video_out #(
      .DATA_W(DATA_W), .PIX_ROW(PIX_ROW), .ROWS(ROWS),
      .HBLANK(HBLANK), .SLOW_DIV(SLOW_DIV)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   int checkCount = 0;
   int failCount = 0;
   expPix_t sbQueue[$];
   expPix_t monItem;
   logic expBc;
   logic [9:0] expLine;

   logic [DATA_W-1:0] bufMem [2][PIX_ROW];
   logic [DATA_W-1:0] bufData;
   logic [9:0]        bufAddr;
   logic [2:0]        bufRdCnt;

   assign bus.i_buf_data = bufData;

   // Buffer read port: fast mode streams with one cycle latency, slow mode
   // registers the address first and the data one edge later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bufData  <= '0;
         bufAddr  <= '0;
         bufRdCnt <= '0;
      end else if (bus.o_bufer_out_en) begin
         if (bus.o_low_speed_out) begin
            bufAddr <= bus.o_pix_out;
            bufData <= bufMem[bus.o_bufer_change][bufAddr[2:0]];
         end else begin
            bufData  <= bufMem[bus.o_bufer_change][bufRdCnt];
            bufRdCnt <= bufRdCnt + 3'd1;
         end
      end else begin
         bufData  <= '0;
         bufRdCnt <= '0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Pulses LINE_READY for one cycle; an accepted line loads the half about to
   // be selected and queues its pixels. Returns in the cycle after the sampling edge.
   task automatic applyStimulus(input logic expectAccept, input int tag);
      expPix_t item;
      if (expectAccept) begin
         for (int i = 0; i < PIX_ROW; i++) begin
            bufMem[~expBc][i] = DATA_W'(tag * 100 + i * 7 + 1);
            item.data    = DATA_W'(tag * 100 + i * 7 + 1);
            item.lineNum = expLine;
            item.first   = (i == 0);
            sbQueue.push_back(item);
         end
         expBc = ~expBc;
      end
      bus.i_line_ready = 1'b1;
      @(negedge clk);
      bus.i_line_ready = 1'b0;
   endtask

   task automatic advanceLine();
      expLine = (expLine == 10'(ROWS - 1)) ? 10'd0 : 10'(expLine + 10'd1);
   endtask

   task automatic runFastLine();
      logic lastRow;
      lastRow = (expLine == 10'(ROWS - 1));
      checkOutput("bcToggle", 32'(bus.o_bufer_change), 32'(expBc));
      checkOutput("swapEn", 32'(bus.o_bufer_out_en), 32'd0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checkOutput("fastEn", 32'(bus.o_bufer_out_en), 32'(k <= 8));
         checkOutput("fastPv", 32'(bus.o_pix_valid), 32'(k >= 3 && k <= 10));
         checkOutput("fastLv", 32'(bus.o_line_valid), 32'(k >= 3 && k <= 10));
         checkOutput("fastLowSpeed", 32'(bus.o_low_speed_out), 32'd0);
         checkOutput("fastPixOut", 32'(bus.o_pix_out), 32'd0);
         if (k == 11) begin
            advanceLine();
            checkOutput("lineNum", 32'(bus.o_line_num), 32'(expLine));
            checkOutput("frameDone", 32'(bus.o_frame_done), 32'(lastRow));
         end
         if (k == 12)
            checkOutput("frameDoneOnce", 32'(bus.o_frame_done), 32'd0);
      end
   endtask

   task automatic runSlowLine(input logic toggleTo);
      logic lastRow;
      lastRow = (expLine == 10'(ROWS - 1));
      checkOutput("bcToggleSlow", 32'(bus.o_bufer_change), 32'(expBc));
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (k == 10)
            bus.i_slow_mode = toggleTo;
         checkOutput("slowEn", 32'(bus.o_bufer_out_en), 32'(k <= 32));
         checkOutput("slowLowSpeed", 32'(bus.o_low_speed_out), 32'(k <= 32));
         checkOutput("slowPixOut", 32'(bus.o_pix_out), (k <= 32) ? 32'((k - 1) / SLOW_DIV) : 32'd0);
         checkOutput("slowPv", 32'(bus.o_pix_valid), 32'(k <= 32 && ((k - 1) % SLOW_DIV) == 3));
         checkOutput("slowLv", 32'(bus.o_line_valid), 32'(k >= 4 && k <= 32));
         if (k == 35) begin
            advanceLine();
            checkOutput("lineNumSlow", 32'(bus.o_line_num), 32'(expLine));
            checkOutput("frameDoneSlow", 32'(bus.o_frame_done), 32'(lastRow));
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Bc"}, 32'(bus.o_bufer_change), 32'd0);
      checkOutput({tag, "En"}, 32'(bus.o_bufer_out_en), 32'd0);
      checkOutput({tag, "Low"}, 32'(bus.o_low_speed_out), 32'd0);
      checkOutput({tag, "PixOut"}, 32'(bus.o_pix_out), 32'd0);
      checkOutput({tag, "PixData"}, 32'(bus.o_pix_data), 32'd0);
      checkOutput({tag, "Pv"}, 32'(bus.o_pix_valid), 32'd0);
      checkOutput({tag, "Lv"}, 32'(bus.o_line_valid), 32'd0);
      checkOutput({tag, "Fs"}, 32'(bus.o_frame_start), 32'd0);
      checkOutput({tag, "Fd"}, 32'(bus.o_frame_done), 32'd0);
      checkOutput({tag, "LineNum"}, 32'(bus.o_line_num), 32'd0);
      checkOutput({tag, "Overrun"}, 32'(bus.o_overrun), 32'd0);
   endtask

   // Scoreboard side: every valid pixel pops one expected entry.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_pix_valid) begin
            checkOutput("sbNonEmpty", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
               monItem = sbQueue.pop_front();
               checkOutput("pixData", 32'(bus.o_pix_data), 32'(monItem.data));
               checkOutput("pixLineNum", 32'(bus.o_line_num), 32'(monItem.lineNum));
               checkOutput("frameStart", 32'(bus.o_frame_start),
                           32'(monItem.first && monItem.lineNum == 10'd0));
               checkOutput("lineValidWithPix", 32'(bus.o_line_valid), 32'd1);
            end
         end else begin
            checkOutput("frameStartIdle", 32'(bus.o_frame_start), 32'd0);
         end
      end
   end

   initial begin
      bus.i_line_ready = 1'b0;
      bus.i_slow_mode  = 1'b0;
      expBc   = 1'b0;
      expLine = 10'd0;
      for (int h = 0; h < 2; h++)
         for (int i = 0; i < PIX_ROW; i++)
            bufMem[h][i] = '0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      $display("[TB] fast line, row 0");
      applyStimulus(1'b1, 1);
      runFastLine();

      $display("[TB] slow line, row 1, mode toggled mid-line");
      bus.i_slow_mode = 1'b1;
      applyStimulus(1'b1, 2);
      runSlowLine(1'b0);

      $display("[TB] fast line, row 2, end of frame");
      applyStimulus(1'b1, 3);
      runFastLine();
      checkOutput("bcThreeToggles", 32'(bus.o_bufer_change), 32'd1);

      $display("[TB] request during last blank cycle");
      applyStimulus(1'b1, 4);
      checkOutput("overrunBefore", 32'(bus.o_overrun), 32'd0);
      repeat (10) @(negedge clk);
      applyStimulus(1'b0, 0);
      checkOutput("overrunBlank", 32'(bus.o_overrun), 32'd1);
      checkOutput("bcHeldBlank", 32'(bus.o_bufer_change), 32'(expBc));
      advanceLine();
      checkOutput("lineNumAfterDrop", 32'(bus.o_line_num), 32'(expLine));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("noLineAfterDrop", 32'(bus.o_bufer_out_en), 32'd0);
      end

      $display("[TB] request during line");
      applyStimulus(1'b1, 5);
      repeat (4) @(negedge clk);
      applyStimulus(1'b0, 0);
      checkOutput("bcHeldLine", 32'(bus.o_bufer_change), 32'(expBc));
      checkOutput("overrunLine", 32'(bus.o_overrun), 32'd1);
      repeat (7) @(negedge clk);
      advanceLine();
      checkOutput("lineNumAfterLineDrop", 32'(bus.o_line_num), 32'(expLine));
      checkOutput("overrunSticky", 32'(bus.o_overrun), 32'd1);

      $display("[TB] reset at pixel 4 of a fast line");
      applyStimulus(1'b1, 6);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1 checkAllZero("midReset");
      sbQueue.delete();
      expBc   = 1'b0;
      expLine = 10'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 7);
      runFastLine();

      repeat (3) @(negedge clk);
      checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end
endmodule
